// File: rtl/piano_pkg.sv
// Shared definitions for the piano player: transport states, loop modes,
// button indices and top-level mode codes.
package piano_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2
  } transport_e;

  // Any loop_mode with bit 1 set behaves as sequential-wrap.
  localparam logic [1:0] LOOP_STOP = 2'b00;
  localparam logic [1:0] LOOP_ONE  = 2'b01;
  localparam logic [1:0] LOOP_SEQ  = 2'b10;

  localparam int BTN_PREV  = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_NEXT  = 2;

  localparam logic [2:0] MODE_AUTO   = 3'b011;
  localparam logic [2:0] MODE_MANUAL = 3'b001;
  localparam logic [2:0] MODE_STUDY  = 3'b111;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, stability counter and a registered
// single-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_prev_q, press_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: every register here holds state across edges, so all updates use
  // non-blocking assignments; blocking ones would let sync2_q see btn_raw
  // in the same edge and collapse the synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/song_selector.sv
// Song-selection and transport controller: debounced prev/pause/next buttons,
// STOPPED/PLAYING/PAUSED FSM, end-of-song looping and one-hot song LEDs.
module song_selector
  import piano_pkg::*;
#(
  parameter int NUM_SONGS       = 4,
  parameter int SEL_W           = $clog2(NUM_SONGS),
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           button,
  input  logic                 enable,
  input  logic [1:0]           loop_mode,
  input  logic                 song_done,
  output logic [SEL_W-1:0]     song_num,
  output logic [NUM_SONGS-1:0] song_onehot,
  output logic                 playing,
  output logic                 paused,
  output logic                 song_start
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SONGS - 1);

  logic [2:0]       press;
  transport_e       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             start_q, start_d;

  for (genvar b = 0; b < 3; b++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (button[b]),
      .press   (press[b])
    );
  end

  // Wrap explicitly at NUM_SONGS so non-power-of-two song counts work.
  function automatic logic [SEL_W-1:0] idx_inc(input logic [SEL_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [SEL_W-1:0] idx_dec(input logic [SEL_W-1:0] i);
    return (i == '0) ? LAST_IDX : i - 1'b1;
  endfunction

  // NOTE: each next-state signal takes its hold value first, so no path
  // through the if/case tree leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    start_d   = 1'b0;
    if (!enable) begin
      state_d   = ST_STOPPED;
      pending_d = 1'b0;
    end else if (press[BTN_PAUSE]) begin
      unique case (state_q)
        ST_STOPPED: begin
          state_d   = ST_PLAYING;
          start_d   = 1'b1;
          pending_d = 1'b0;
        end
        ST_PLAYING: state_d = ST_PAUSED;
        ST_PAUSED: begin
          state_d   = ST_PLAYING;
          start_d   = pending_q;
          pending_d = 1'b0;
        end
        default: state_d = ST_STOPPED;
      endcase
    end else if (press[BTN_NEXT] || press[BTN_PREV]) begin
      idx_d = press[BTN_NEXT] ? idx_inc(idx_q) : idx_dec(idx_q);
      if (state_q == ST_PLAYING) start_d   = 1'b1;
      if (state_q == ST_PAUSED)  pending_d = 1'b1;
    end else if (song_done && state_q == ST_PLAYING) begin
      if (loop_mode == LOOP_STOP) begin
        state_d = ST_STOPPED;
      end else if (loop_mode == LOOP_ONE) begin
        start_d = 1'b1;
      end else begin
        idx_d   = idx_inc(idx_q);
        start_d = 1'b1;
      end
    end
  end

  // NOTE: only control registers exist here, and all of them get a defined
  // value on the asynchronous reset so the LEDs and strobe are clean at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_STOPPED;
      idx_q     <= '0;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      start_q   <= start_d;
    end
  end

  // Decoded from the index register so LEDs and song_num move on the same edge.
  always_comb begin
    song_onehot = '0;
    for (int i = 0; i < NUM_SONGS; i++) begin
      song_onehot[i] = (idx_q == SEL_W'(i));
    end
  end

  assign song_num   = idx_q;
  assign playing    = (state_q == ST_PLAYING);
  assign paused     = (state_q == ST_PAUSED);
  assign song_start = start_q;

endmodule

// File: tb/tb_song_selector.sv
// Directed bench for song_selector with NUM_SONGS=5, DEBOUNCE_CYCLES=4:
// a table of button/song_done actions plus hand-written timing corner cases.
module tb_song_selector;

  localparam int NS = 5;
  localparam int SW = $clog2(NS);

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    button;
  logic          enable;
  logic [1:0]    loop_mode;
  logic          song_done;
  logic [SW-1:0] song_num;
  logic [NS-1:0] song_onehot;
  logic          playing, paused, song_start;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  logic prev_start = 1'b0;

  song_selector #(.NUM_SONGS(NS), .DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .button      (button),
    .enable      (enable),
    .loop_mode   (loop_mode),
    .song_done   (song_done),
    .song_num    (song_num),
    .song_onehot (song_onehot),
    .playing     (playing),
    .paused      (paused),
    .song_start  (song_start)
  );

  always #5 clk = ~clk;

  typedef enum int {A_PREV, A_PAUSE, A_NEXT, A_DONE} act_e;

  typedef struct {
    act_e       act;
    logic [1:0] loop;
    int         exp_num;
    int         exp_play;
    int         exp_pause;
    int         exp_starts;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input int num, input int ply,
                             input int pse);
    check({tag, " song_num"}, int'(song_num), num);
    check({tag, " onehot"}, int'(song_onehot), 1 << num);
    check({tag, " playing"}, int'(playing), ply);
    check({tag, " paused"}, int'(paused), pse);
  endtask

  // Any song_start must be a single-cycle strobe.
  always @(negedge clk) begin
    if (song_start) begin
      start_cnt++;
      check("start_single_cycle", int'(prev_start), 0);
    end
    prev_start = song_start;
  end

  task automatic do_action(input act_e a, input logic [1:0] lm);
    @(negedge clk);
    loop_mode = lm;
    if (a == A_DONE) begin
      song_done = 1'b1;
      @(negedge clk);
      song_done = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      case (a)
        A_PREV:  button[0] = 1'b1;
        A_PAUSE: button[1] = 1'b1;
        default: button[2] = 1'b1;
      endcase
      repeat (8) @(negedge clk);
      button = 3'b000;
      repeat (10) @(negedge clk);
    end
  endtask

  initial begin
    int s0;
    vecs[0]  = '{A_PREV,  2'b10, 0, 0, 0, 0};
    vecs[1]  = '{A_PREV,  2'b10, 4, 0, 0, 0};
    vecs[2]  = '{A_NEXT,  2'b10, 0, 0, 0, 0};
    vecs[3]  = '{A_NEXT,  2'b10, 1, 0, 0, 0};
    vecs[4]  = '{A_PAUSE, 2'b10, 1, 1, 0, 1};
    vecs[5]  = '{A_PAUSE, 2'b10, 1, 0, 1, 0};
    vecs[6]  = '{A_NEXT,  2'b10, 2, 0, 1, 0};
    vecs[7]  = '{A_PAUSE, 2'b10, 2, 1, 0, 1};
    vecs[8]  = '{A_PAUSE, 2'b10, 2, 0, 1, 0};
    vecs[9]  = '{A_PAUSE, 2'b10, 2, 1, 0, 0};
    vecs[10] = '{A_NEXT,  2'b10, 3, 1, 0, 1};
    vecs[11] = '{A_NEXT,  2'b10, 4, 1, 0, 1};
    vecs[12] = '{A_DONE,  2'b10, 0, 1, 0, 1};
    vecs[13] = '{A_PREV,  2'b10, 4, 1, 0, 1};
    vecs[14] = '{A_DONE,  2'b01, 4, 1, 0, 1};
    vecs[15] = '{A_DONE,  2'b11, 0, 1, 0, 1};
    vecs[16] = '{A_PREV,  2'b11, 4, 1, 0, 1};
    vecs[17] = '{A_DONE,  2'b00, 4, 0, 0, 0};
    vecs[18] = '{A_DONE,  2'b10, 4, 0, 0, 0};
    vecs[19] = '{A_PAUSE, 2'b10, 4, 1, 0, 1};
    vecs[20] = '{A_PAUSE, 2'b10, 4, 0, 1, 0};
    vecs[21] = '{A_DONE,  2'b10, 4, 0, 1, 0};
    vecs[22] = '{A_PAUSE, 2'b10, 4, 1, 0, 0};

    rst = 1'b0; button = 3'b000; enable = 1'b1; loop_mode = 2'b10; song_done = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset", 0, 0, 0);
    check("reset song_start", int'(song_start), 0);
    rst = 1'b1;
    @(negedge clk);

    // Exact latency: raw rise before edge 1, index updates on edge 8.
    s0 = start_cnt;
    button[2] = 1'b1;
    repeat (7) @(posedge clk);
    #1 check("latency edge7 song_num", int'(song_num), 0);
    @(posedge clk);
    #1 check("latency edge8 song_num", int'(song_num), 1);
    check("latency edge8 onehot", int'(song_onehot), 5'b00010);
    repeat (2) @(negedge clk);
    button = 3'b000;
    repeat (10) @(negedge clk);
    check_state("hold_next", 1, 0, 0);
    check("hold_next starts", start_cnt - s0, 0);

    for (int i = 0; i < 23; i++) begin
      s0 = start_cnt;
      do_action(vecs[i].act, vecs[i].loop);
      check_state($sformatf("vec%0d", i), vecs[i].exp_num, vecs[i].exp_play,
                  vecs[i].exp_pause);
      check($sformatf("vec%0d starts", i), start_cnt - s0, vecs[i].exp_starts);
    end

    // Two-cycle glitches never reach the debounce threshold.
    s0 = start_cnt;
    @(negedge clk);
    for (int r = 0; r < 6; r++) begin
      button[2] = 1'b1; @(negedge clk);
      @(negedge clk);
      button[2] = 1'b0; @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check_state("glitch", 4, 1, 0);
    check("glitch starts", start_cnt - s0, 0);
    s0 = start_cnt;
    do_action(A_NEXT, 2'b10);
    check_state("clean_after_glitch", 0, 1, 0);
    check("clean_after_glitch starts", start_cnt - s0, 1);

    // Pause and next on the same cycle: pause wins, next is dropped.
    s0 = start_cnt;
    @(negedge clk);
    button = 3'b110;
    repeat (8) @(negedge clk);
    button = 3'b000;
    repeat (10) @(negedge clk);
    check_state("pause_beats_next", 0, 0, 1);
    check("pause_beats_next starts", start_cnt - s0, 0);
    do_action(A_PAUSE, 2'b10);
    check_state("resume", 0, 1, 0);

    // Dropping enable stops on the next edge and ignores presses.
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1 check_state("enable_off", 0, 0, 0);
    s0 = start_cnt;
    do_action(A_NEXT, 2'b10);
    check_state("enable_off_next", 0, 0, 0);
    check("enable_off starts", start_cnt - s0, 0);
    enable = 1'b1;
    do_action(A_NEXT, 2'b10);
    do_action(A_PAUSE, 2'b10);
    check_state("replay", 1, 1, 0);

    // Asynchronous reset in the middle of a debounce.
    @(negedge clk);
    button[2] = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_state("async_rst", 0, 0, 0);
    check("async_rst song_start", int'(song_start), 0);
    button = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check_state("after_rst", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
